// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared constants and blitter state encoding for the Chip-8 core.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

    localparam int FBUF_AW   = 9;
    localparam int MEM_AW    = 12;

    localparam int LORES_WPL = 4;
    localparam int HIRES_WPL = 8;

    localparam int LORES_W   = 64;
    localparam int LORES_H   = 32;
    localparam int HIRES_W   = 128;
    localparam int HIRES_H   = 64;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_MREQ   = 4'd1,
        ST_MCAP   = 4'd2,
        ST_RD0    = 4'd3,
        ST_WR0    = 4'd4,
        ST_RD1    = 4'd5,
        ST_WR1    = 4'd6,
        ST_NEXT   = 4'd7,
        ST_FIN    = 4'd8,
        ST_MREQ_B = 4'd9,
        ST_MCAP_B = 4'd10
    } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_row_align.sv
`default_nettype none
// ============================================================================
// Module      : sprite_row_align
// Description : Shifts a sprite row into a 32-bit two-word field and decides
//               whether the second word lies on screen and needs writing.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_row_align
    import chip8_pkg::*;
(
    input  logic [15:0] i_pat,
    input  logic [6:0]  i_x0,
    input  logic        i_hires,
    output logic [15:0] o_f_hi,
    output logic [15:0] o_f_lo,
    output logic [2:0]  o_w,
    output logic        o_second
);

    logic [31:0] w_field;
    logic [3:0]  w_w_next;
    logic [3:0]  w_wpl;

    assign w_field  = {i_pat, 16'h0000} >> i_x0[3:0];
    assign o_f_hi   = w_field[31:16];
    assign o_f_lo   = w_field[15:0];
    assign o_w      = i_x0[6:4];

    // Pixels past the last word of the line are dropped, not wrapped.
    assign w_w_next = {1'b0, i_x0[6:4]} + 4'd1;
    assign w_wpl    = i_hires ? 4'(HIRES_WPL) : 4'(LORES_WPL);
    assign o_second = (o_f_lo != 16'h0000) && (w_w_next < w_wpl);

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter
// Description : DXYN executor: fetches sprite rows and XORs them into the
//               packed framebuffer over a read-modify-write port, tracking
//               collision. Define CHIP8_SPRITE16_EN for 16x16 SCHIP sprites.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter
    import chip8_pkg::*;
#(
    parameter int FBUF_AW = chip8_pkg::FBUF_AW,
    parameter int MEM_AW  = chip8_pkg::MEM_AW
) (
    input  logic               clk,
    input  logic               res,
    input  logic               hires,
    input  logic               start,
    input  logic [7:0]         x,
    input  logic [7:0]         y,
    input  logic [3:0]         n,
    input  logic [MEM_AW-1:0]  i_addr,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [7:0]         mem_data,
    output logic [FBUF_AW-1:0] fbuf_addr,
    input  logic [15:0]        fbuf_rdata,
    output logic [15:0]        fbuf_wdata,
    output logic               fbuf_we,
    output logic               busy,
    output logic               done,
    output logic               collision
);

    blit_state_t        r_state;
    blit_state_t        w_state_nxt;
    logic [6:0]         r_x0;
    logic [5:0]         r_y0;
    logic [4:0]         r_rows;
    logic [4:0]         r_row;
    logic [MEM_AW-1:0]  r_base;
    logic               r_hires;
    logic [15:0]        r_pat;
    logic               r_coll;

    logic [6:0]         w_x0_in;
    logic [5:0]         w_y0_in;
    logic [4:0]         w_rows_in;
    logic               w_s16_in;
    logic               w_s16;
    logic [6:0]         w_line;
    logic [6:0]         w_line_nxt;
    logic [4:0]         w_row_nxt;
    logic               w_bottom;
    logic [5:0]         w_fetch_off;
    logic [FBUF_AW-1:0] w_base_addr;
    logic [15:0]        w_f_hi;
    logic [15:0]        w_f_lo;
    logic [2:0]         w_w;
    logic               w_second;
    logic               w_unused;

    assign w_unused    = ^{x[7], y[7:6]};

    assign w_x0_in     = hires ? x[6:0] : {1'b0, x[5:0]};
    assign w_y0_in     = hires ? y[5:0] : {1'b0, y[4:0]};
    assign w_rows_in   = w_s16_in ? 5'd16 : {1'b0, n};

    assign w_line      = {1'b0, r_y0} + {2'b00, r_row};
    assign w_line_nxt  = w_line + 7'd1;
    assign w_row_nxt   = r_row + 5'd1;
    assign w_bottom    = r_hires ? (w_line_nxt >= 7'(HIRES_H)) : (w_line_nxt >= 7'(LORES_H));
    assign w_fetch_off = w_s16 ? {r_row, 1'b0} : {1'b0, r_row};
    assign w_base_addr = r_hires ? (FBUF_AW'(w_line) << 3) : (FBUF_AW'(w_line) << 2);

`ifdef CHIP8_SPRITE16_EN
    logic r_s16;

    assign w_s16_in = hires && (n == 4'd0);
    assign w_s16    = r_s16;

    always_ff @(posedge clk) begin
        if (res) begin
            r_s16 <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_s16 <= w_s16_in;
        end
    end
`else
    assign w_s16_in = 1'b0;
    assign w_s16    = 1'b0;
`endif

    sprite_row_align u_align (
        .i_pat    (r_pat),
        .i_x0     (r_x0),
        .i_hires  (r_hires),
        .o_f_hi   (w_f_hi),
        .o_f_lo   (w_f_lo),
        .o_w      (w_w),
        .o_second (w_second)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_rows  <= '0;
            r_row   <= '0;
            r_base  <= '0;
            r_hires <= 1'b0;
            r_pat   <= '0;
            r_coll  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x0    <= w_x0_in;
                        r_y0    <= w_y0_in;
                        r_rows  <= w_rows_in;
                        r_row   <= '0;
                        r_base  <= i_addr;
                        r_hires <= hires;
                        r_coll  <= 1'b0;
                    end
                end
                ST_MCAP:   r_pat       <= {mem_data, 8'h00};
                ST_MCAP_B: r_pat[7:0]  <= mem_data;
                ST_WR0:    r_coll      <= r_coll | (|(fbuf_rdata & w_f_hi));
                ST_WR1:    r_coll      <= r_coll | (|(fbuf_rdata & w_f_lo));
                ST_NEXT:   r_row       <= w_row_nxt;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = (w_rows_in == 5'd0) ? ST_FIN : ST_MREQ;
            ST_MREQ:   w_state_nxt = ST_MCAP;
            ST_MCAP:   w_state_nxt = w_s16 ? ST_MREQ_B : ST_RD0;
            ST_MREQ_B: w_state_nxt = ST_MCAP_B;
            ST_MCAP_B: w_state_nxt = ST_RD0;
            ST_RD0:    w_state_nxt = ST_WR0;
            ST_WR0:    w_state_nxt = w_second ? ST_RD1 : ST_NEXT;
            ST_RD1:    w_state_nxt = ST_WR1;
            ST_WR1:    w_state_nxt = ST_NEXT;
            // Rows stop at the bottom edge rather than wrapping to the top.
            ST_NEXT:   w_state_nxt = ((w_row_nxt == r_rows) || w_bottom) ? ST_FIN : ST_MREQ;
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr   = '0;
        mem_rd     = 1'b0;
        fbuf_addr  = '0;
        fbuf_wdata = '0;
        fbuf_we    = 1'b0;
        busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
        done       = (r_state == ST_FIN);
        collision  = r_coll;
        case (r_state)
            ST_MREQ: begin
                mem_rd   = 1'b1;
                mem_addr = r_base + MEM_AW'(w_fetch_off);
            end
            ST_MREQ_B: begin
                mem_rd   = 1'b1;
                mem_addr = r_base + MEM_AW'(w_fetch_off) + MEM_AW'(1);
            end
            ST_RD0: begin
                fbuf_addr = w_base_addr + FBUF_AW'(w_w);
            end
            ST_WR0: begin
                fbuf_addr  = w_base_addr + FBUF_AW'(w_w);
                fbuf_wdata = fbuf_rdata ^ w_f_hi;
                fbuf_we    = 1'b1;
            end
            ST_RD1: begin
                fbuf_addr = w_base_addr + FBUF_AW'(w_w) + FBUF_AW'(1);
            end
            ST_WR1: begin
                fbuf_addr  = w_base_addr + FBUF_AW'(w_w) + FBUF_AW'(1);
                fbuf_wdata = fbuf_rdata ^ w_f_lo;
                fbuf_we    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Scoreboard bench for sprite_blitter with a pixel-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

    typedef struct {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic coll;
        int   lat;
    } dn_t;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        hires = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic [3:0]  n = '0;
    logic [11:0] i_addr = '0;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = '0;
    logic [8:0]  fbuf_addr;
    logic [15:0] fbuf_rdata = '0;
    logic [15:0] fbuf_wdata;
    logic        fbuf_we;
    logic        busy;
    logic        done;
    logic        collision;

    logic [7:0]  mem [0:4095];
    logic [15:0] ram [0:511];
    logic [15:0] mfb [0:511];

    wr_t wq[$];
    dn_t dq[$];
    int  checks = 0;
    int  errors = 0;
    int  bcnt   = 0;

    sprite_blitter dut (
        .clk        (clk),
        .res        (res),
        .hires      (hires),
        .start      (start),
        .x          (x),
        .y          (y),
        .n          (n),
        .i_addr     (i_addr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .fbuf_addr  (fbuf_addr),
        .fbuf_rdata (fbuf_rdata),
        .fbuf_wdata (fbuf_wdata),
        .fbuf_we    (fbuf_we),
        .busy       (busy),
        .done       (done),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
        fbuf_rdata <= ram[fbuf_addr];
        if (fbuf_we) ram[fbuf_addr] <= fbuf_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plot each sprite pixel on screen, then group into words.
    task automatic model_draw(input bit h, input logic [7:0] xx, input logic [7:0] yy,
                              input logic [3:0] nn, input logic [11:0] a, input bit want_done);
        int W, H, WPL, x0, y0, rows, width, lat, line, w, pat, px, base;
        logic coll;
        logic [15:0] m0, m1;
        W = h ? 128 : 64;
        H = h ? 64 : 32;
        WPL = h ? 8 : 4;
        x0 = int'(xx) % W;
        y0 = int'(yy) % H;
        rows = int'(nn);
        width = 8;
        lat = 0;
        coll = 1'b0;
`ifdef CHIP8_SPRITE16_EN
        if (h && nn == 4'd0) begin
            rows = 16;
            width = 16;
        end
`endif
        for (int r = 0; r < rows; r++) begin
            line = y0 + r;
            if (line >= H) break;
            if (width == 16) pat = int'({mem[int'(a) + 2*r], mem[int'(a) + 2*r + 1]});
            else             pat = int'(mem[int'(a) + r]);
            w = x0 / 16;
            m0 = '0;
            m1 = '0;
            for (int k = 0; k < width; k++) begin
                if (pat[width-1-k]) begin
                    px = x0 + k;
                    if (px < W) begin
                        if (px / 16 == w) m0[15 - px % 16] = 1'b1;
                        else              m1[15 - px % 16] = 1'b1;
                    end
                end
            end
            base = line * WPL + w;
            wq.push_back('{9'(base), mfb[base] ^ m0});
            if ((mfb[base] & m0) != 16'h0) coll = 1'b1;
            mfb[base] = mfb[base] ^ m0;
            lat += (width == 16) ? 7 : 5;
            if (m1 != 16'h0) begin
                wq.push_back('{9'(base + 1), mfb[base+1] ^ m1});
                if ((mfb[base+1] & m1) != 16'h0) coll = 1'b1;
                mfb[base+1] = mfb[base+1] ^ m1;
                lat += 2;
            end
        end
        if (want_done) dq.push_back('{coll, lat});
    endtask

    always @(negedge clk) begin
        if (fbuf_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h required none", fbuf_addr, fbuf_wdata);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", 32'(fbuf_addr), 32'(e.a));
                chk("wr_data", 32'(fbuf_wdata), 32'(e.d));
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual done=1 required 0");
            end else begin
                dn_t e;
                e = dq.pop_front();
                chk("collision", 32'(collision), 32'(e.coll));
                chk("latency", 32'(bcnt), 32'(e.lat));
            end
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end else begin
            bcnt = 0;
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int c = 0; c < 50 && (busy || done); c++) @(negedge clk);
    endtask

    task automatic draw(input bit h, input logic [7:0] xx, input logic [7:0] yy,
                        input logic [3:0] nn, input logic [11:0] a, input bit disturb);
        bit seen;
        wait_idle();
        model_draw(h, xx, yy, nn, a, 1'b1);
        hires = h; x = xx; y = yy; n = nn; i_addr = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            // Inputs changed mid-draw must not affect the running draw.
            if (disturb && c == 2) begin
                start = 1'b1;
                hires = ~h;
                x = 8'($urandom);
                n = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int k;
        int bad;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 512; i++) begin
            ram[i] = '0;
            mfb[i] = '0;
        end
        mem[12'h200] = 8'hF0;
        mem[12'h210] = 8'hFF;
        for (int i = 0; i < 5; i++) mem[12'h220 + i] = 8'hFF;
        mem[12'h230] = 8'h80;

        res = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_coll", 32'(collision), 0);
        chk("rst_we", 32'(fbuf_we), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_fbuf_addr", 32'(fbuf_addr), 0);
        chk("rst_fbuf_wdata", 32'(fbuf_wdata), 0);
        res = 1'b0;

        draw(1'b0, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0);
        chk("t1_ram0", 32'(ram[0]), 32'hF000);
        chk("t1_coll", 32'(collision), 0);

        draw(1'b0, 8'd12, 8'd1, 4'd1, 12'h210, 1'b0);
        chk("t2_ram4", 32'(ram[4]), 32'h000F);
        chk("t2_ram5", 32'(ram[5]), 32'hF000);

        draw(1'b0, 8'd12, 8'd1, 4'd1, 12'h210, 1'b0);
        chk("t3_ram4", 32'(ram[4]), 32'h0000);
        chk("t3_ram5", 32'(ram[5]), 32'h0000);
        chk("t3_coll", 32'(collision), 1);

        draw(1'b0, 8'd60, 8'd30, 4'd5, 12'h220, 1'b0);
        chk("t4_ram123", 32'(ram[123]), 32'h000F);
        chk("t4_ram127", 32'(ram[127]), 32'h000F);
        draw(1'b0, 8'd70, 8'd3, 4'd2, 12'h220, 1'b0);

        draw(1'b1, 8'd127, 8'd63, 4'd1, 12'h230, 1'b0);
        chk("t5_ram511", 32'(ram[511]), 32'h0001);
        draw(1'b1, 8'd127, 8'd63, 4'd1, 12'h230, 1'b0);
        chk("t5_coll", 32'(collision), 1);

        draw(1'b1, 8'd8, 8'd0, 4'd0, 12'h240, 1'b0);
        draw(1'b0, 8'd8, 8'd0, 4'd0, 12'h240, 1'b0);

        // Reset during the third row's write: first three writes stay.
        wait_idle();
        model_draw(1'b0, 8'd0, 8'd5, 4'd3, 12'h240, 1'b0);
        hires = 1'b0; x = 8'd0; y = 8'd5; n = 4'd4; i_addr = 12'h240; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 100; c++) begin
            if (fbuf_we) k++;
            if (k == 3) break;
            @(negedge clk);
        end
        chk("t6_writes", 32'(k), 3);
        res = 1'b1;
        @(negedge clk);
        chk("t6_we", 32'(fbuf_we), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        res = 1'b0;
        repeat (10) @(negedge clk);
        draw(1'b0, 8'd0, 8'd5, 4'd4, 12'h240, 1'b0);

        // start together with reset is dropped
        wait_idle();
        res = 1'b1; start = 1'b1; n = 4'd3;
        @(negedge clk);
        res = 1'b0; start = 1'b0;
        chk("rs_busy0", 32'(busy), 0);
        @(negedge clk);
        chk("rs_busy1", 32'(busy), 0);

        for (int t = 0; t < 40; t++) begin
            draw(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 4'($urandom_range(0, 15)), 12'($urandom_range(12'h300, 12'hF00)),
                 1'($urandom_range(0, 1)));
        end

        wait_idle();
        chk("wq_empty", 32'(wq.size()), 0);
        chk("dq_empty", 32'(dq.size()), 0);
        bad = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== mfb[i]) bad++;
        chk("fb_final", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
